if_fetch_cached: RTL
====================

Name: if_fetch_cached

Overview:
- Parametrised successor of the IF stage: PC register, next-PC selection, direct-mapped instruction cache and its AXI read-burst refill engine in one block.
- Sits between the hazard unit / ID redirect logic and the instruction AXI master port. Feeds instr/PC to the IF/ID register.
- Adds configurable geometry, whole-cache invalidate and a pending-invalidate rule across refills.
- The AXI write channels are not in this block; the top ties them off.

Parameters:
- WIDTH, 32, data/address width. Only 32 is legal.
- LINE_WORDS, 8, words per cache line. Power of two, 2..16; arlen = LINE_WORDS-1.
- SETS, 64, number of cache sets. Power of two, 2..256.
- RESET_PC, 32'hbfc0_0000, PC loaded on reset.
- EXC_PC, 32'hbfc0_0380, exception vector.
- AXI_ID, 4'd0, value driven on arid.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall_f  in  1  hazard-unit hold of PC
- exc_valid  in  1  exception redirect request
- eret_valid  in  1  return-from-exception request; target is epc
- epc  in  32  ERET target
- redirect_valid  in  1  branch/jump taken
- redirect_pc  in  32  branch/jump target
- icache_inv  in  1  invalidate all lines (one-cycle pulse)
- pc  out  32  current fetch PC
- pc_add_4  out  32  pc+4
- is_new_pc  out  1  pc differs from previous cycle's pc
- instr  out  32  fetched word; valid when miss_stall=0
- miss_stall  out  1  fetch not complete; pipeline must hold
- arid, araddr, arlen, arsize, arburst  out  4/32/4/3/2  AXI AR channel
- arvalid  out  1  AXI AR valid
- arready  in  1  AXI AR ready
- rdata  in  32  AXI R data
- rlast, rvalid  in  1/1  AXI R last beat / valid
- rready  out  1  AXI R ready

Behaviour:
- Address split:
  - OFF = log2(LINE_WORDS)+2 bits
  - IDX = log2(SETS) bits
  - index = pc[OFF+IDX-1:OFF], word = pc[OFF-1:2], tag = pc[31:OFF+IDX]
- Reset values: pc=RESET_PC; previous-PC register=0, so is_new_pc=1 in the first cycle after reset. All valid bits=0, FSM=IDLE, arvalid=0, rready=0, pending-inv=0.
- PC update priority, evaluated at posedge:
  1. rst
  2. exc_valid && !miss_stall -> EXC_PC
  3. stall_f || miss_stall -> hold
  4. eret_valid -> epc
  5. redirect_valid -> redirect_pc
  6. otherwise pc+4
- Sources hold exc_valid until they observe miss_stall=0.
- hit = valid[index] && tag_ram[index]==tag. Read is combinational: a hit gives instr in the same cycle, miss_stall=0.
- miss_stall = !hit || state!=IDLE.
- FSM:
  - IDLE: on !hit -> AR. araddr={pc[31:OFF],OFF'b0}, arlen=LINE_WORDS-1, arsize=3'b010, arburst=2'b01.
  - AR: arvalid=1, address stable until arready -> R.
  - R: rready=1. Each rvalid writes rdata to data_ram[index][beat]; beat increments and wraps at LINE_WORDS. On rvalid&&rlast -> FILL. rlast is trusted regardless of beat count.
  - FILL: write tag. Set valid unless pending-inv is set, in which case the line stays invalid and pending-inv is cleared. -> IDLE.
  - The next IDLE cycle re-evaluates hit. Minimum miss penalty = LINE_WORDS+3 cycles with zero-wait AXI.
- pc is frozen during a refill, so the index used for the fill is the stalled pc's index.
- icache_inv:
  - In IDLE: clear all valid bits at posedge; a hit in that same cycle still returns data.
  - In AR/R/FILL: set pending-inv.
- rst mid-burst: FSM returns to IDLE immediately and all valid bits clear. AXI slave reset is tied to !rst, so no burst drain is needed.
- pc_add_4 wraps modulo 2^32.

Optional Feature:
- Macro: ICACHE_KSEG1_UNCACHED_EN
- With the macro:
  - pc[31:29]==3'b101 bypasses the cache via a single beat: arlen=0, araddr=pc.
  - The word is captured in a one-entry buffer tagged with the full pc; the cache arrays and valid bits are untouched.
  - hit for such a pc = buffer valid && buffer tag==pc.
  - icache_inv also clears the buffer.
- Without the macro: all addresses are cached identically.

Test Plan:
- Reset, zero-wait AXI, macro off: araddr=0xbfc0_0000, arlen=7, arburst=01. After 8 beats + FILL, instr=beat0 data, miss_stall=0, pc=0xbfc0_0000. The next 7 sequential fetches hit, arvalid=0.
- Redirect to 0xbfc0_0100 (index 8) then to 0xbfc0_0900 (same index, different tag) -> two refills. Returning to 0x100 misses again, confirming eviction.
- exc_valid raised during a refill -> pc unchanged until miss_stall=0, then pc=0xbfc0_0380 the following cycle.
- icache_inv pulsed in R state of the refill of line 0 -> after FILL, valid[0]=0 and an immediate re-miss on the same pc.
- arready delayed 5 cycles and rvalid gapped every other beat -> araddr stable throughout, all 8 words stored in order, exact data match.
- Macro on: fetch 0xbfc0_0004 -> arlen=0, no cache write. Repeat fetch returns from the buffer with no AR. Fetch 0x8000_0000 -> arlen=7 burst.

Source files
------------

// File: rtl/if_fetch_cached.sv
// IF stage with PC register, next-PC select, direct-mapped I-cache and AXI read-burst refill.
// Optional ICACHE_KSEG1_UNCACHED_EN: pc[31:29]==3'b101 bypasses the cache through a one-entry buffer.
module if_fetch_cached #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned SETS       = 64,
    parameter logic [31:0] RESET_PC   = 32'hbfc0_0000,
    parameter logic [31:0] EXC_PC     = 32'hbfc0_0380,
    parameter logic [3:0]  AXI_ID     = 4'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_f,
    input  logic             exc_valid,
    input  logic             eret_valid,
    input  logic [WIDTH-1:0] epc,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             icache_inv,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_add_4,
    output logic             is_new_pc,
    output logic [WIDTH-1:0] instr,
    output logic             miss_stall,
    output logic [3:0]       arid,
    output logic [WIDTH-1:0] araddr,
    output logic [3:0]       arlen,
    output logic [2:0]       arsize,
    output logic [1:0]       arburst,
    output logic             arvalid,
    input  logic             arready,
    input  logic [WIDTH-1:0] rdata,
    input  logic             rlast,
    input  logic             rvalid,
    output logic             rready
);
    localparam int unsigned OFF  = $clog2(LINE_WORDS) + 2;
    localparam int unsigned IDX  = $clog2(SETS);
    localparam int unsigned TAGW = WIDTH - OFF - IDX;
    localparam int unsigned WW   = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_FILL = 2'd3
    } state_t;

    state_t           state_r, state_next_s;
    logic [WIDTH-1:0] pc_r, prev_pc_r, pc_next_s;
    logic [SETS-1:0]  valid_r;
    logic [TAGW-1:0]  tag_ram_r  [SETS];
    logic [WIDTH-1:0] data_ram_r [SETS][LINE_WORDS];
    logic [WW-1:0]    beat_r;
    logic             pend_inv_r;
    logic [IDX-1:0]   index_s;
    logic [WW-1:0]    word_s;
    logic [TAGW-1:0]  tag_s;
    logic             cache_hit_s, hit_s, uncached_s, miss_stall_s;

    assign index_s     = pc_r[OFF+IDX-1:OFF];
    assign word_s      = pc_r[OFF-1:2];
    assign tag_s       = pc_r[WIDTH-1:OFF+IDX];
    assign cache_hit_s = valid_r[index_s] && (tag_ram_r[index_s] == tag_s);

`ifdef ICACHE_KSEG1_UNCACHED_EN
    logic             buf_valid_r;
    logic [WIDTH-1:0] buf_tag_r, buf_data_r;

    assign uncached_s = (pc_r[WIDTH-1:WIDTH-3] == 3'b101);
    assign hit_s      = uncached_s ? (buf_valid_r && (buf_tag_r == pc_r)) : cache_hit_s;
    assign instr      = uncached_s ? buf_data_r : data_ram_r[index_s][word_s];
    assign araddr     = uncached_s ? pc_r : {pc_r[WIDTH-1:OFF], {OFF{1'b0}}};
    assign arlen      = uncached_s ? 4'd0 : 4'(LINE_WORDS - 1);

    // Uncached buffer: captures the single beat, tagged with the full pc at FILL.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_r <= 1'b0;
            buf_tag_r   <= {WIDTH{1'b0}};
            buf_data_r  <= {WIDTH{1'b0}};
        end else begin
            if (state_r == S_R && rvalid && uncached_s) begin
                buf_data_r <= rdata;
            end
            if (icache_inv) begin
                buf_valid_r <= 1'b0;
            end else if (state_r == S_FILL && uncached_s) begin
                buf_valid_r <= !pend_inv_r;
                buf_tag_r   <= pc_r;
            end
        end
    end
`else
    assign uncached_s = 1'b0;
    assign hit_s      = cache_hit_s;
    assign instr      = data_ram_r[index_s][word_s];
    assign araddr     = {pc_r[WIDTH-1:OFF], {OFF{1'b0}}};
    assign arlen      = 4'(LINE_WORDS - 1);
`endif

    assign miss_stall_s = !hit_s || (state_r != S_IDLE);
    assign miss_stall   = miss_stall_s;
    assign pc           = pc_r;
    assign pc_add_4     = pc_r + 32'd4;
    assign is_new_pc    = (pc_r != prev_pc_r);
    assign arid         = AXI_ID;
    assign arsize       = 3'b010;
    assign arburst      = 2'b01;
    assign arvalid      = (state_r == S_AR);
    assign rready       = (state_r == S_R);

    // Next-PC priority: exceptions only redirect once the current fetch has completed.
    always_comb begin
        pc_next_s = pc_r + 32'd4;
        if (exc_valid && !miss_stall_s) begin
            pc_next_s = EXC_PC;
        end else if (stall_f || miss_stall_s) begin
            pc_next_s = pc_r;
        end else if (eret_valid) begin
            pc_next_s = epc;
        end else if (redirect_valid) begin
            pc_next_s = redirect_pc;
        end else begin
            pc_next_s = pc_r + 32'd4;
        end
    end

    // PC and previous-PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r      <= RESET_PC;
            prev_pc_r <= {WIDTH{1'b0}};
        end else begin
            pc_r      <= pc_next_s;
            prev_pc_r <= pc_r;
        end
    end

    // Refill FSM next-state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!hit_s) state_next_s = S_AR;
                else        state_next_s = S_IDLE;
            end
            S_AR: begin
                if (arready) state_next_s = S_R;
                else         state_next_s = S_AR;
            end
            S_R: begin
                if (rvalid && rlast) state_next_s = S_FILL;
                else                 state_next_s = S_R;
            end
            S_FILL:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Refill FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Beat counter and invalidate request that arrived while a refill was in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_r     <= {WW{1'b0}};
            pend_inv_r <= 1'b0;
        end else begin
            if (state_r == S_AR) begin
                beat_r <= {WW{1'b0}};
            end else if (state_r == S_R && rvalid) begin
                beat_r <= beat_r + WW'(1'b1);
            end
            if (state_r == S_FILL) begin
                pend_inv_r <= 1'b0;
            end else if (icache_inv && state_r != S_IDLE) begin
                pend_inv_r <= 1'b1;
            end
        end
    end

    // Data and tag arrays; the stalled pc supplies the fill index.
    always_ff @(posedge clk) begin
        if (state_r == S_R && rvalid && !uncached_s) begin
            data_ram_r[index_s][beat_r] <= rdata;
        end
        if (state_r == S_FILL && !uncached_s) begin
            tag_ram_r[index_s] <= tag_s;
        end
    end

    // Valid bits: invalidate wins over a fill landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {SETS{1'b0}};
        end else if (icache_inv) begin
            valid_r <= {SETS{1'b0}};
        end else if (state_r == S_FILL && !uncached_s) begin
            valid_r[index_s] <= !pend_inv_r;
        end
    end
endmodule
